// File: rtl/cbpa_adder_pkg.sv
// Shared defaults and elaboration helpers for the carry-bypass adder.
package cbpa_adder_pkg;

   localparam int WIDTH_DEF      = 32;
   localparam int BLOCK_DEF      = 4;
   localparam int NUM_BLOCKS_DEF = WIDTH_DEF / BLOCK_DEF;

   // Block count for a given width/block split.
   function automatic int num_blocks(input int width, input int block);
      return width / block;
   endfunction

   // True when the width splits into whole bypass blocks.
   function automatic bit width_ok(input int width, input int block);
      return (block > 0) && (width >= block) && ((width % block) == 0);
   endfunction

endpackage

// File: rtl/cbpa_adder_if.sv
// Operand/result bundle between an adder user (master) and the adder (slave).
interface cbpa_adder_if #(
   parameter int WIDTH = 32
) ();

   logic signed [WIDTH-1:0] a;
   logic signed [WIDTH-1:0] b;
   logic                    cin;
   logic signed [WIDTH-1:0] sum;
   logic                    cout;
   logic                    of;

   modport master (output a, output b, output cin,
                   input  sum, input cout, input of);

   modport slave  (input  a, input b, input cin,
                   output sum, output cout, output of);

endinterface

// File: rtl/cbpa_adder_block.sv
// One carry-bypass block: BLOCK-bit ripple adder whose carry-out is replaced
// by the block carry-in whenever every bit propagates.
module cbpa_block #(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] i_a,
   input  logic [BLOCK-1:0] i_b,
   input  logic             i_cin,
   output logic [BLOCK-1:0] o_sum,
   output logic             o_cout,
   output logic             o_cmsb
);

   logic [BLOCK-1:0] w_p;
   logic [BLOCK-1:0] w_g;
   logic             w_c;
   logic             w_bp;

   assign w_p  = i_a ^ i_b;
   assign w_g  = i_a & i_b;
   assign w_bp = &w_p;

   // Ripple carry through the block, capturing the carry into its MSB.
   always_comb begin
      w_c    = i_cin;
      o_sum  = '0;
      o_cmsb = 1'b0;
      for (int i = 0; i < BLOCK; i++) begin
         o_sum[i] = w_p[i] ^ w_c;
         if (i == BLOCK - 1) o_cmsb = w_c;
         w_c = w_g[i] | (w_p[i] & w_c);
      end
   end

   // Bypass mux: an all-propagate block passes its carry-in straight through.
   assign o_cout = w_bp ? i_cin : w_c;

endmodule

// File: rtl/cbpa_adder.sv
// 32-bit (default) carry-bypass adder with carry-in, carry-out and signed
// overflow, followed by one output register stage.
module cbpa_adder
   import cbpa_adder_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int BLOCK = BLOCK_DEF
) (
   input  logic         clk,
   input  logic         rst,
   cbpa_adder_if.slave  bus
);

   localparam int NUM_BLOCKS = num_blocks(WIDTH, BLOCK);

   if (!width_ok(WIDTH, BLOCK)) begin : g_bad_split
      $error("cbpa_adder: WIDTH must be a positive multiple of BLOCK");
   end

   logic [WIDTH-1:0]        w_sum;
   logic                    w_cout;
   logic                    w_cmsb;
   logic signed [WIDTH-1:0] r_sum;
   logic                    r_cout;
   logic                    r_of;

   // Each block gets its own carry nets so the chain has no self-referencing vector.
   for (genvar k = 0; k < NUM_BLOCKS; k++) begin : g_blk
      logic w_bcin;
      logic w_bcout;
      logic w_bcmsb;

      if (k == 0) begin : g_first
         assign w_bcin = bus.cin;
      end else begin : g_next
         assign w_bcin = g_blk[k-1].w_bcout;
      end

      cbpa_block #(.BLOCK(BLOCK)) u_blk (
         .i_a    (bus.a[k*BLOCK +: BLOCK]),
         .i_b    (bus.b[k*BLOCK +: BLOCK]),
         .i_cin  (w_bcin),
         .o_sum  (w_sum[k*BLOCK +: BLOCK]),
         .o_cout (w_bcout),
         .o_cmsb (w_bcmsb)
      );
   end

   assign w_cout = g_blk[NUM_BLOCKS-1].w_bcout;
   assign w_cmsb = g_blk[NUM_BLOCKS-1].w_bcmsb;

   // ---- output register stage: reset clears the result, otherwise load every cycle ----
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sum  <= '0;
         r_cout <= 1'b0;
         r_of   <= 1'b0;
      end else begin
         r_sum  <= w_sum;
         r_cout <= w_cout;
         r_of   <= w_cmsb ^ w_cout;
      end
   end

   assign bus.sum  = r_sum;
   assign bus.cout = r_cout;
   assign bus.of   = r_of;

endmodule

// File: tb/tb_cbpa_adder.sv
// Directed-vector bench for cbpa_adder with a queue-based scoreboard.
module tb_cbpa_adder;

   logic clk;
   logic rst;

   cbpa_adder_if #(.WIDTH(32)) bus ();

   cbpa_adder #(.WIDTH(32), .BLOCK(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] sum;
      logic        cout;
      logic        of;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Drive one operand set before the next rising edge and queue its expected result.
   task automatic step(input logic r, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic [31:0] es, input logic ec,
                       input logic eo, input string nm);
      exp_t e;
      @(negedge clk);
      rst     = r;
      bus.a   = a;
      bus.b   = b;
      bus.cin = ci;
      e.sum   = es;
      e.cout  = ec;
      e.of    = eo;
      e.name  = nm;
      sb.push_back(e);
   endtask

   // Monitor: one result per edge whenever an expectation is pending.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (bus.sum === e.sum && bus.cout === e.cout && bus.of === e.of) begin
               n_pass++;
            end else begin
               $display("FAIL %s: got sum=%h cout=%b of=%b, expected sum=%h cout=%b of=%b",
                        e.name, bus.sum, bus.cout, bus.of, e.sum, e.cout, e.of);
            end
         end
      end
   end

   initial begin
      int wait_cyc;
      rst     = 1'b1;
      bus.a   = '0;
      bus.b   = '0;
      bus.cin = 1'b0;

      // Reset held two cycles with overflowing operands present.
      step(1, 32'h7fffffff, 32'h7fffffff, 0, 32'h00000000, 0, 0, "reset_0");
      step(1, 32'h7fffffff, 32'h7fffffff, 0, 32'h00000000, 0, 0, "reset_1");
      // First valid result one edge after deassert, then back-to-back vectors.
      step(0, 32'h7fffffff, 32'h7fffffff, 0, 32'hfffffffe, 0, 1, "pos_pos_of");
      step(0, 32'h8fffffff, 32'h8fffffff, 0, 32'h1ffffffe, 1, 1, "neg_neg_of");
      step(0, 32'h000007aa, 32'hffffffff, 0, 32'h000007a9, 1, 0, "mixed_1");
      step(0, 32'h00000123, 32'hfffff123, 0, 32'hfffff246, 0, 0, "mixed_2");
      step(0, 32'hfffff999, 32'h00000111, 0, 32'hfffffaaa, 0, 0, "mixed_3");
      step(0, 32'h000000af, 32'h000000af, 1, 32'h0000015f, 0, 0, "cin_small");
      step(0, 32'hffffffff, 32'hffffffff, 0, 32'hfffffffe, 1, 0, "ones_ones");
      step(0, 32'h00000000, 32'hffffffff, 0, 32'hffffffff, 0, 0, "bypass_cin0");
      step(0, 32'h00000000, 32'hffffffff, 1, 32'h00000000, 1, 0, "bypass_cin1");
      step(0, 32'h7fffffff, 32'h7fffffff, 1, 32'hffffffff, 0, 1, "maxpos_cin1");
      step(0, 32'h80000000, 32'h80000000, 0, 32'h00000000, 1, 1, "cout_and_of");
      // Mid-stream reset must win over live operands.
      step(1, 32'h12345678, 32'h87654321, 1, 32'h00000000, 0, 0, "reset_mid");
      step(0, 32'h00000001, 32'hffffffff, 0, 32'h00000000, 1, 0, "gen_ripple");
      step(0, 32'h12345678, 32'h87654321, 0, 32'h99999999, 0, 0, "no_carry");
      step(0, 32'h0ffffff0, 32'h00000010, 0, 32'h10000000, 0, 0, "partial_skip");
      step(0, 32'h0000000f, 32'h00000001, 0, 32'h00000010, 0, 0, "block0_carry");

      // Idle and let the monitor drain, with a bounded wait.
      @(negedge clk);
      rst = 1'b0;
      wait_cyc = 0;
      while (sb.size() > 0 && wait_cyc < 10) begin
         @(negedge clk);
         wait_cyc++;
      end
      if (sb.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
